// File: rtl/delay_line_ctrl.sv
// Circular sample delay line over an asynchronous RAM: for each accepted sample,
// read the sample written `delay` samples earlier, return it, then write the new one.
module delay_line_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  input  logic [ADDR_WIDTH-1:0] delay,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] ram_address,
  inout  wire  [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_we,
  output logic                  ram_oe
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WS, S_WR, S_WH} state_t;

  localparam logic [ADDR_WIDTH:0]   DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0]   sample_out_q, sample_out_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]   din_q;
  logic [ADDR_WIDTH-1:0]   dly_q;
  logic [ADDR_WIDTH-1:0]   rd_addr_q;
  logic [ADDR_WIDTH-1:0]   dly_c;
  logic [ADDR_WIDTH-1:0]   rd_addr_d;
  logic                    accept;
  logic                    bus_drv;

  assign accept = (state_q == S_IDLE) && sample_valid;

  // Clamp, then wrap the read pointer without a wide intermediate: when
  // wr_ptr < dly the true result wr_ptr + DEPTH - dly is below DEPTH.
  always_comb begin
    dly_c = ({1'b0, delay} >= DEPTH_X) ? LAST : delay;
    if (wr_ptr_q >= dly_c) rd_addr_d = wr_ptr_q - dly_c;
    else                   rd_addr_d = wr_ptr_q + (LAST - dly_c) + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      sample_out_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      sample_out_q <= sample_out_d;
      overflow_q   <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      din_q     <= sample_in;
      dly_q     <= dly_c;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    sample_out_d = sample_out_q;
    overflow_d   = overflow_q | (sample_valid && (state_q != S_IDLE));
    case (state_q)
      S_IDLE: if (sample_valid) state_d = S_RD;
      S_RD: begin
        state_d      = S_WS;
        sample_out_d = (dly_q == '0) ? din_q : ram_data;
      end
      S_WS: state_d = S_WR;
      S_WR: state_d = S_WH;
      S_WH: begin
        state_d  = S_IDLE;
        wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != S_IDLE);
    out_valid   = (state_q == S_WS);
    ram_we      = (state_q == S_WR);
    ram_oe      = (state_q == S_RD) && (dly_q != '0);
    bus_drv     = 1'b0;
    ram_address = '0;
    case (state_q)
      S_RD:             ram_address = rd_addr_q;
      S_WS, S_WR, S_WH: begin
        ram_address = wr_ptr_q;
        bus_drv     = 1'b1;
      end
      default: ;
    endcase
  end

  assign ram_data   = bus_drv ? din_q : {DATA_WIDTH{1'bz}};
  assign sample_out = sample_out_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/delay_line_ctrl.md
Name: delay_line_ctrl

Overview:
- Sequential controller that turns the asynchronous delay RAM into a circular sample delay line for one surround channel.
- Sits directly upstream of the delay RAM: accepts one audio sample per request and drives the RAM address, bidirectional data bus, WE and OE.
- For each accepted sample, reads the sample written `delay` samples earlier, returns it, then writes the new sample at the write pointer.

Parameters:
- DATA_WIDTH, 16, sample width; must equal the RAM data width.
- ADDR_WIDTH, 10, RAM address width.
- DEPTH, 1024, RAM depth in samples; 2 <= DEPTH <= 2^ADDR_WIDTH, and need not be a power of two.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- sample_in  input  DATA_WIDTH  new sample.
- sample_valid  input  1  request; accepted only when busy=0.
- delay  input  ADDR_WIDTH  delay in samples; latched at accept.
- sample_out  output  DATA_WIDTH  delayed sample (registered).
- out_valid  output  1  one-cycle pulse; sample_out is valid.
- busy  output  1  high while a transaction is in progress.
- overflow  output  1  sticky; a request arrived while busy.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_data  inout  DATA_WIDTH  RAM data bus; driven only in write states, else high-Z.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values (applied asynchronously, including mid-transaction):
  - state=IDLE; wr_ptr=0; sample_out=0; out_valid=0; overflow=0.
  - ram_we=0; ram_oe=0; ram_address=0; ram_data released to Z.
- All outputs are registered or decoded from the state register only. No combinational path exists from inputs to RAM controls.
- Accept: at a rising edge with state=IDLE and sample_valid=1:
  - latch sample_in into din_r and delay into dly_r;
  - compute rd_addr = (wr_ptr >= dly_r) ? wr_ptr - dly_r : wr_ptr + DEPTH - dly_r;
  - if dly_r > DEPTH-1, clamp dly_r to DEPTH-1 first.
- State sequence: IDLE -> RD -> WS -> WR -> WH -> IDLE, one cycle per state.
- RD state:
  - ram_address=rd_addr; ram_oe=1; ram_we=0; bus at Z.
  - At the edge leaving RD, sample_out <= ram_data.
  - If dly_r=0 (bypass): ram_oe stays 0, and sample_out <= din_r.
- WS state:
  - ram_address=wr_ptr; ram_data driven with din_r; ram_oe=0; ram_we=0.
  - out_valid=1 for this cycle only.
- WR state: same address and data as WS; ram_we=1.
- WH state:
  - ram_we=0; address and data still held.
  - At the edge leaving WH: wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1, and the bus is released.
- busy = (state != IDLE).
  - Minimum spacing between accepted samples is 5 clocks.
  - Latency: accept edge E0 -> out_valid high in the cycle after edge E1 (2nd cycle after accept).
- Overflow: sample_valid=1 while busy=1.
  - The sample is dropped and no state changes.
  - overflow is set and stays 1 until reset.
- Bus safety:
  - ram_we and ram_oe are never both 1.
  - The data bus is never driven while ram_oe=1.
  - Address and data are stable for the full cycle before, during and after ram_we=1.
- Unwritten locations read back the RAM power-up content (all ones). The controller applies no masking.
- Delay changes take effect per sample, at accept.

Test Plan:
- Reset release, then a request with sample_in=0x1234, delay=3 -> ram_oe=1 at address 1021 in RD; out_valid pulse with sample_out=0xFFFF; write of 0x1234 at address 0 with a one-cycle ram_we; wr_ptr=1 afterwards.
- Stream samples 1..8 with delay=3, 5-clock spacing -> sample_out sequence FFFF,FFFF,FFFF,1,2,3,4,5.
- Delay=0, sample_in=0x00AA -> ram_oe never asserts; sample_out=0x00AA; write still occurs.
- Feed DEPTH+2 samples with delay=1 -> wr_ptr wraps 1023->0; the sample written at 1023 is returned when wr_ptr=0 (read address 1023).
- sample_valid held high continuously -> one accept per 5 clocks; overflow=1 after the first busy-cycle request; dropped samples never appear in RAM.
- Assert rst during the WR state -> ram_we and ram_oe drop immediately, the bus goes to Z, and overflow and wr_ptr clear; a throughout-bench check confirms ram_we & ram_oe is never 1.
